led_display_arbiter: RTL and testbench



---
 rtl/led_display_pkg.sv | 30 +++
 rtl/led_display_arbiter_if.sv | 32 +++
 rtl/led_rr_pick.sv | 31 +++
 rtl/led_display_arbiter.sv | 158 +++++++++++++++
 tb/tb_led_display_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_display_pkg.sv
// Shared types and constants for the LED display arbiter slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: arb_state_t, SEG_W, segment bit indices, blank_pattern().
package led_display_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT       = 2'd1,
    COMMIT_WAIT = 2'd2
  } arb_state_t;

  localparam int SEG_W = 8;

  // Bit positions inside a segment byte laid out as {A,B,C,D,E,F,G,DP}.
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Every segment driven to its inactive level.
  function automatic logic [SEG_W-1:0] blank_pattern(input logic valid_signal);
    return {SEG_W{~valid_signal}};
  endfunction

endpackage

// File: rtl/led_display_arbiter_if.sv
// Per-requester digit write bus into the display arbiter.
// Latency: n/a (wires only).
// Backpressure: wr_ready per requester; a beat moves on wr_valid & wr_ready.
// Ports: wr_valid, wr_ready, wr_sel (digit index), wr_data (segments), wr_last.
interface led_display_arbiter_if
  import led_display_pkg::*;
#(
  parameter int NUM     = 4,
  parameter int REQ_NUM = 3
) ();

  localparam int SEL_W = (NUM > 1) ? $clog2(NUM) : 1;

  logic [REQ_NUM-1:0]                 wr_valid;
  logic [REQ_NUM-1:0]                 wr_ready;
  logic [REQ_NUM-1:0][SEL_W-1:0]      wr_sel;
  logic [REQ_NUM-1:0][SEG_W-1:0]      wr_data;
  logic [REQ_NUM-1:0]                 wr_last;

  // Requester side.
  modport master (
    output wr_valid, wr_sel, wr_data, wr_last,
    input  wr_ready
  );

  // Arbiter side.
  modport slave (
    input  wr_valid, wr_sel, wr_data, wr_last,
    output wr_ready
  );

endinterface

// File: rtl/led_rr_pick.sv
// Round-robin priority picker: first set bit of req at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; hit=0 when req is empty.
// Ports: req (request vector), ptr (start index), hit (any found), idx (winner).
module led_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          hit,
  output logic [PW-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        hit = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin arbiter collecting digit write bursts into a shadow buffer,
// committed atomically to led_out on the first frame_tick after a burst.
// Latency: 1 cycle grant, shadow write 1 cycle after beat, commit on next tick.
// Backpressure: wr_ready only for the owner in GRANT; others wait.
// Ports: clk/rstn, wr (slave bus), frame_tick, led_out, owner, busy, sel_err.
module led_display_arbiter
  import led_display_pkg::*;
#(
  parameter int   NUM          = 4,
  parameter int   REQ_NUM      = 3,
  parameter logic VALID_SIGNAL = 1'b0,
  parameter int   MAX_BURST    = 8,
  parameter int   IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  led_display_arbiter_if.slave          wr,
  input  logic                          frame_tick,
  output logic [NUM-1:0][SEG_W-1:0]     led_out,
  output logic [$clog2(REQ_NUM)-1:0]    owner,
  output logic                          busy,
  output logic                          sel_err
);

  localparam int SEL_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int OW    = $clog2(REQ_NUM);
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int TW    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [SEG_W-1:0] BLANK = blank_pattern(VALID_SIGNAL);

  arb_state_t                  state_q, state_d;
  logic [OW-1:0]               owner_q, owner_d;
  logic [OW-1:0]               ptr_q, ptr_d;
  logic [BW-1:0]               beat_q;
  logic [TW-1:0]               idle_q;
  logic [NUM-1:0][SEG_W-1:0]   shadow_q;
  logic [NUM-1:0][SEG_W-1:0]   led_q;
  logic                        sel_err_q;

  logic                        pick_hit;
  logic [OW-1:0]               pick_idx;

  logic                        own_vld;
  logic                        own_last;
  logic [SEL_W-1:0]            own_sel;
  logic [SEG_W-1:0]            own_dat;
  logic                        beat_acc;
  logic                        sel_ok;
  logic                        burst_end;
  logic                        idle_expired;

  led_rr_pick #(
    .N  (REQ_NUM),
    .PW (OW)
  ) u_pick (
    .req (wr.wr_valid),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign own_vld  = wr.wr_valid[owner_q];
  assign own_last = wr.wr_last[owner_q];
  assign own_sel  = wr.wr_sel[owner_q];
  assign own_dat  = wr.wr_data[owner_q];

  assign beat_acc = (state_q == GRANT) && own_vld;
  assign sel_ok   = int'(own_sel) < NUM;

  // beat_q counts beats already taken, so the MAX_BURST-th beat sees MAX_BURST-1.
  assign burst_end    = beat_acc && (own_last || (beat_q == BW'(MAX_BURST - 1)));
  assign idle_expired = (state_q == GRANT) && !own_vld &&
                        (idle_q == TW'(IDLE_TIMEOUT - 1));

  always_comb begin
    wr.wr_ready = '0;
    if (state_q == GRANT) begin
      wr.wr_ready[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (burst_end || idle_expired) begin
          state_d = COMMIT_WAIT;
          ptr_d   = (owner_q == OW'(REQ_NUM - 1)) ? '0 : owner_q + OW'(1);
        end
      end
      COMMIT_WAIT: begin
        if (frame_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Both counters restart with every grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_q <= '0;
      idle_q <= '0;
    end else if (state_q != GRANT) begin
      beat_q <= '0;
      idle_q <= '0;
    end else if (beat_acc) begin
      beat_q <= beat_q + BW'(1);
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end

  // Out-of-range beats still count toward the burst but leave the shadow alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q  <= {NUM{BLANK}};
      led_q     <= {NUM{BLANK}};
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= beat_acc && !sel_ok;
      if (beat_acc && sel_ok) begin
        shadow_q[own_sel] <= own_dat;
      end
      if ((state_q == COMMIT_WAIT) && frame_tick) begin
        led_q <= shadow_q;
      end
    end
  end

  assign led_out = led_q;
  assign owner   = owner_q;
  assign busy    = (state_q != IDLE);
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_led_display_arbiter.sv
// Scoreboard bench for led_display_arbiter: expected frames and grant order
// are queued as stimulus is driven and popped when the DUT commits or grants.
// A second instance with NUM=5 exercises the out-of-range digit select path.
module tb_led_display_arbiter;
  import led_display_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic frame_tick = 1'b0;
  always #5 clk = ~clk;

  led_display_arbiter_if #(.NUM(4), .REQ_NUM(3)) if4 ();
  led_display_arbiter_if #(.NUM(5), .REQ_NUM(3)) if5 ();

  logic [3:0][7:0] led_out;
  logic [1:0]      owner;
  logic            busy, sel_err;
  logic [4:0][7:0] led5;
  logic [1:0]      owner5;
  logic            busy5, sel_err5;

  led_display_arbiter #(.NUM(4), .REQ_NUM(3), .VALID_SIGNAL(1'b0),
                        .MAX_BURST(8), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .wr(if4), .frame_tick(frame_tick),
    .led_out(led_out), .owner(owner), .busy(busy), .sel_err(sel_err)
  );

  led_display_arbiter #(.NUM(5), .REQ_NUM(3), .VALID_SIGNAL(1'b0),
                        .MAX_BURST(8), .IDLE_TIMEOUT(16)) dut5 (
    .clk(clk), .rstn(rstn), .wr(if5), .frame_tick(frame_tick),
    .led_out(led5), .owner(owner5), .busy(busy5), .sel_err(sel_err5)
  );

  int checks = 0;
  int errors = 0;
  int se_cnt = 0;
  logic [31:0]     exp_q[$];
  logic [1:0]      exp_owner_q[$];
  logic [3:0][7:0] m_sh;

  always @(negedge clk) if (sel_err5) se_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sh = {4{8'hFF}};
    exp_q.delete();
    exp_owner_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    model_reset();
    step();
  endtask

  // Holds the beat until the arbiter accepts it, then updates the model.
  task automatic drive_beat(input int r, input int sel, input logic [7:0] d,
                            input bit last, input bit on5);
    bit ok;
    ok = 1'b0;
    if (on5) begin
      if5.wr_valid[r] = 1'b1; if5.wr_sel[r] = 3'(sel);
      if5.wr_data[r] = d;     if5.wr_last[r] = last;
    end else begin
      if4.wr_valid[r] = 1'b1; if4.wr_sel[r] = 2'(sel);
      if4.wr_data[r] = d;     if4.wr_last[r] = last;
    end
    for (int c = 0; c < 40 && !ok; c++) begin
      if ((on5 ? if5.wr_ready[r] : if4.wr_ready[r]) === 1'b1) ok = 1'b1;
      step();
    end
    if (on5) begin
      if5.wr_valid[r] = 1'b0; if5.wr_last[r] = 1'b0;
    end else begin
      if4.wr_valid[r] = 1'b0; if4.wr_last[r] = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL beat_accept: req %0d never saw wr_ready, required within 40 cycles", r);
    end else if (!on5 && sel < 4) begin
      m_sh[sel] = d;
    end
  endtask

  // Pulses frame_tick and pops the expected frame once the commit edge passes.
  task automatic do_commit(input string name);
    logic [31:0] exp;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: commit with empty scoreboard, led_out %h", name, led_out);
    end else begin
      exp = exp_q.pop_front();
      if (led_out !== exp) begin
        errors++;
        $display("FAIL %s: led_out %h required %h", name, led_out, exp);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    checks++;
    if (led_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_led: %h required ffffffff", led_out); end
    checks++;
    if ({if4.wr_ready, busy, owner, sel_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready %b busy %b owner %0d sel_err %b required all zero",
               if4.wr_ready, busy, owner, sel_err);
    end
    rstn = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_basic();
    drive_beat(1, 0, 8'hC0, 1'b0, 1'b0);
    drive_beat(1, 1, 8'hF9, 1'b1, 1'b0);
    exp_q.push_back(m_sh);
    checks++;
    if (busy !== 1'b1 || if4.wr_ready !== 3'b000) begin
      errors++; $display("FAIL basic_wait: busy %b ready %b required 1 000", busy, if4.wr_ready);
    end
    repeat (4) step();
    checks++;
    if (led_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_early: %h required ffffffff", led_out); end
    do_commit("basic_commit");
    checks++;
    if (owner !== 2'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after: owner %0d busy %b required 1 0", owner, busy);
    end
  endtask

  task automatic test_rr();
    logic [1:0] exp_o;
    bit seen;
    do_reset();
    if4.wr_valid[0] = 1'b1; if4.wr_sel[0] = 2'd2; if4.wr_data[0] = 8'hA4; if4.wr_last[0] = 1'b1;
    if4.wr_valid[2] = 1'b1; if4.wr_sel[2] = 2'd3; if4.wr_data[2] = 8'hB0; if4.wr_last[2] = 1'b1;
    exp_owner_q.push_back(2'd0);
    exp_owner_q.push_back(2'd2);
    exp_owner_q.push_back(2'd0);
    for (int b = 0; b < 3; b++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        if (if4.wr_ready !== 3'b000) seen = 1'b1;
        else step();
      end
      exp_o = exp_owner_q.pop_front();
      checks++;
      if (!seen || owner !== exp_o || if4.wr_ready !== (3'b001 << exp_o)) begin
        errors++;
        $display("FAIL rr_grant%0d: owner %0d ready %b required owner %0d", b, owner, if4.wr_ready, exp_o);
      end
      if (exp_o == 2'd0) m_sh[2] = 8'hA4; else m_sh[3] = 8'hB0;
      exp_q.push_back(m_sh);
      step();
      checks++;
      if (busy !== 1'b1 || if4.wr_ready !== 3'b000 || owner !== exp_o) begin
        errors++;
        $display("FAIL rr_wait%0d: busy %b ready %b owner %0d required 1 000 %0d", b, busy, if4.wr_ready, owner, exp_o);
      end
      do_commit("rr_commit");
    end
    if4.wr_valid = '0;
    if4.wr_last = '0;
    step();
    checks++;
    if (owner !== 2'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rr_idle: owner %0d busy %b required 0 0", owner, busy);
    end
  endtask

  task automatic test_max_burst();
    bit leaked;
    for (int i = 0; i < 8; i++) begin
      drive_beat(1, i % 4, 8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == 6) begin
        checks++;
        if (if4.wr_ready[1] !== 1'b1) begin errors++; $display("FAIL burst_7th: ready %b required 1", if4.wr_ready[1]); end
      end
    end
    exp_q.push_back(m_sh);
    checks++;
    if (if4.wr_ready !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL burst_cap: ready %b busy %b required 000 1", if4.wr_ready, busy);
    end
    if4.wr_valid[1] = 1'b1; if4.wr_sel[1] = 2'd0; if4.wr_data[1] = 8'h18;
    leaked = 1'b0;
    repeat (5) begin
      step();
      if (if4.wr_ready !== 3'b000) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin errors++; $display("FAIL burst_regrant_early: ready seen before commit, required none"); end
    do_commit("burst_commit");
    step();
    checks++;
    if (owner !== 2'd1 || if4.wr_ready !== 3'b010) begin
      errors++; $display("FAIL burst_regrant: owner %0d ready %b required 1 010", owner, if4.wr_ready);
    end
    drive_beat(1, 0, 8'h18, 1'b0, 1'b0);
    drive_beat(1, 1, 8'h19, 1'b1, 1'b0);
    exp_q.push_back(m_sh);
    do_commit("burst_tail_commit");
  endtask

  task automatic test_timeout();
    drive_beat(0, 0, 8'h11, 1'b0, 1'b0);
    drive_beat(0, 1, 8'h22, 1'b0, 1'b0);
    exp_q.push_back(m_sh);
    repeat (15) step();
    checks++;
    if (if4.wr_ready[0] !== 1'b1) begin errors++; $display("FAIL timeout_early: ready %b after 15 idle, required 1", if4.wr_ready[0]); end
    step();
    checks++;
    if (if4.wr_ready !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_revoke: ready %b busy %b required 000 1", if4.wr_ready, busy);
    end
    do_commit("timeout_commit");
  endtask

  task automatic test_sel_err();
    se_cnt = 0;
    drive_beat(0, 5, 8'h00, 1'b1, 1'b1);
    repeat (3) step();
    checks++;
    if (se_cnt !== 1) begin errors++; $display("FAIL sel_err_pulse: %0d pulses required 1", se_cnt); end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    checks++;
    if (led5 !== {5{8'hFF}}) begin errors++; $display("FAIL sel_err_led: %h required ffffffffff", led5); end
    se_cnt = 0;
    drive_beat(0, 4, 8'h99, 1'b1, 1'b1);
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    checks++;
    if (se_cnt !== 0 || led5 !== {8'h99, {4{8'hFF}}}) begin
      errors++; $display("FAIL sel_ok_digit4: pulses %0d led %h required 0 99ffffffff", se_cnt, led5);
    end
  endtask

  task automatic test_tick_coincident();
    logic [31:0] prev;
    bit seen;
    prev = led_out;
    if4.wr_valid[2] = 1'b1; if4.wr_sel[2] = 2'd3; if4.wr_data[2] = 8'h55; if4.wr_last[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (if4.wr_ready[2] === 1'b1) seen = 1'b1;
      else step();
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if4.wr_valid[2] = 1'b0; if4.wr_last[2] = 1'b0;
    m_sh[3] = 8'h55;
    exp_q.push_back(m_sh);
    checks++;
    if (!seen || led_out !== prev || busy !== 1'b1) begin
      errors++; $display("FAIL coincident_tick: led %h busy %b required %h 1", led_out, busy, prev);
    end
    repeat (3) step();
    checks++;
    if (led_out !== prev) begin errors++; $display("FAIL coincident_hold: %h required %h", led_out, prev); end
    do_commit("coincident_commit");
  endtask

  task automatic test_reset_wait();
    drive_beat(1, 0, 8'h88, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: %b required 1", busy); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (led_out !== 32'hFFFF_FFFF || busy !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("FAIL rst_async: led %h busy %b owner %0d required ffffffff 0 0", led_out, busy, owner);
    end
    step();
    rstn = 1'b1;
    model_reset();
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    checks++;
    if (led_out !== 32'hFFFF_FFFF || busy !== 1'b0) begin
      errors++; $display("FAIL rst_discard: led %h busy %b required ffffffff 0", led_out, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

  initial begin
    if4.wr_valid = '0; if4.wr_sel = '0; if4.wr_data = '0; if4.wr_last = '0;
    if5.wr_valid = '0; if5.wr_sel = '0; if5.wr_data = '0; if5.wr_last = '0;
    test_reset();
    test_basic();
    test_rr();
    test_max_burst();
    test_timeout();
    test_sel_err();
    test_tick_coincident();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
